// File: rtl/pad_dig_io_bank.sv
// -----------------------------------------------------------------------------
// pad_dig_io_bank
//
// Bank of NCH digital IO channel controllers placed between the GPIO /
// peripheral logic and the per-pin tri-state IO buffers. No inout appears
// here: the pad side uses plain buffer controls (pad_o, pad_t, pad_i).
//
// Output side (registered, one cycle of latency):
//   push-pull  : pad_o = gpio_do, pad_t = cfg_oen
//   open-drain : pad_o = 0,       pad_t = cfg_oen | gpio_do
//
// Input side, per channel:
//   pad_i -> SYNC_STAGES-deep synchroniser -> glitch filter -> gpio_di
//         -> edge pulses gpio_rise / gpio_fall
//         -> sticky irq_stat (write-1 clear, set wins) -> irq (registered OR)
//
// Ports
//   clk, rst       : bank clock, synchronous active-high reset
//   cfg_oen        : per-channel output enable, active low
//   cfg_ien        : per-channel input enable, active low
//   cfg_od_mode    : per-channel 1 = open-drain, 0 = push-pull
//   cfg_filt_en    : per-channel glitch filter enable
//   cfg_filt_len   : shared filter length L
//   gpio_do        : output data from the core
//   gpio_di        : synchronised, filtered input data
//   gpio_rise/fall : one-cycle edge pulses of gpio_di
//   irq_en_rise/fall, irq_clr : interrupt enables and write-1 clear
//   irq_stat, irq  : sticky status and its registered OR
//   pad_i          : pin value from the buffer (asynchronous to clk)
//   pad_o, pad_t   : buffer data and tri-state control (pad_t 1 = hi-Z)
// -----------------------------------------------------------------------------
module pad_dig_io_bank #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    cfg_oen,
    input  logic [NCH-1:0]    cfg_ien,
    input  logic [NCH-1:0]    cfg_od_mode,
    input  logic [NCH-1:0]    cfg_filt_en,
    input  logic [FILT_W-1:0] cfg_filt_len,
    input  logic [NCH-1:0]    gpio_do,
    output logic [NCH-1:0]    gpio_di,
    output logic [NCH-1:0]    gpio_rise,
    output logic [NCH-1:0]    gpio_fall,
    input  logic [NCH-1:0]    irq_en_rise,
    input  logic [NCH-1:0]    irq_en_fall,
    input  logic [NCH-1:0]    irq_clr,
    output logic [NCH-1:0]    irq_stat,
    output logic              irq,
    input  logic [NCH-1:0]    pad_i,
    output logic [NCH-1:0]    pad_o,
    output logic [NCH-1:0]    pad_t
);

    // Effective filter length minus one: a disabled filter or a zero length
    // both behave as L = 1, i.e. a mismatch is accepted on its first cycle.
    function automatic logic [FILT_W-1:0] eff_len_m1(input logic              en,
                                                     input logic [FILT_W-1:0] len);
        if (!en || (len == '0)) begin
            return '0;
        end
        return len - FILT_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Output path
    // -------------------------------------------------------------------------
    logic [NCH-1:0] pad_o_q, pad_o_d;
    logic [NCH-1:0] pad_t_q, pad_t_d;

    always_comb begin
        // Open-drain never drives high: data is held at 0 and the enable is
        // released whenever the core wants a 1.
        pad_o_d = gpio_do & ~cfg_od_mode;
        pad_t_d = cfg_oen | (cfg_od_mode & gpio_do);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_o_q <= '0;
            pad_t_q <= '1;
        end else begin
            pad_o_q <= pad_o_d;
            pad_t_q <= pad_t_d;
        end
    end

    assign pad_o = pad_o_q;
    assign pad_t = pad_t_q;

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------
    // sync_q carries the pin value; svld_q is a parallel chain of 1s that
    // fills behind it after enable, so the last stage of svld_q tells when
    // the synchroniser output reflects the pin again rather than the cleared
    // flops.
    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] svld_q [SYNC_STAGES];
    logic [NCH-1:0] s;
    logic [NCH-1:0] s_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
                svld_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pad_i & ~cfg_ien;
            svld_q[0] <= ~cfg_ien;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1] & ~cfg_ien;
                svld_q[k] <= svld_q[k-1] & ~cfg_ien;
            end
        end
    end

    assign s     = sync_q[SYNC_STAGES-1];
    assign s_vld = svld_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Glitch filter, edge detection and prime handling
    // -------------------------------------------------------------------------
    logic [NCH-1:0]    di_q, di_d;
    logic [NCH-1:0]    rise_q, rise_d;
    logic [NCH-1:0]    fall_q, fall_d;
    logic [NCH-1:0]    prime_q, prime_d;
    logic [FILT_W-1:0] cnt_q [NCH];
    logic [FILT_W-1:0] cnt_d [NCH];
    logic [FILT_W-1:0] lm1;

    always_comb begin
        di_d    = di_q;
        rise_d  = '0;
        fall_d  = '0;
        prime_d = prime_q;
        lm1     = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            lm1      = eff_len_m1(cfg_filt_en[i], cfg_filt_len);
            if (cfg_ien[i]) begin
                // Forced clear on disable; no pulse is produced for it.
                cnt_d[i]   = '0;
                di_d[i]    = 1'b0;
                prime_d[i] = 1'b1;
            end else if (s[i] == di_q[i]) begin
                cnt_d[i] = '0;
                // Agreement only counts once the synchroniser has refilled;
                // before that s is just the cleared flops.
                if (s_vld[i]) begin
                    prime_d[i] = 1'b0;
                end
            end else if (cnt_q[i] >= lm1) begin
                // ">=" so that shortening cfg_filt_len mid-run accepts on the
                // next mismatching cycle instead of wrapping the counter.
                cnt_d[i]   = '0;
                di_d[i]    = s[i];
                prime_d[i] = 1'b0;
                if (!prime_q[i]) begin
                    rise_d[i] =  s[i];
                    fall_d[i] = ~s[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            di_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            prime_q <= '1;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            di_q    <= di_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            prime_q <= prime_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_di   = di_q;
    assign gpio_rise = rise_q;
    assign gpio_fall = fall_q;

    // -------------------------------------------------------------------------
    // Interrupt status
    // -------------------------------------------------------------------------
    logic [NCH-1:0] irq_stat_q, irq_stat_d;
    logic           irq_q;

    always_comb begin
        // The set term is ORed in after the clear, so a simultaneous event
        // keeps the bit high.
        irq_stat_d = (irq_stat_q & ~irq_clr)
                   | (rise_q & irq_en_rise)
                   | (fall_q & irq_en_fall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_stat_q <= irq_stat_d;
            irq_q      <= |irq_stat_q;
        end
    end

    assign irq_stat = irq_stat_q;
    assign irq      = irq_q;

endmodule

// File: doc/pad_dig_io_bank.md
Name: pad_dig_io_bank

Overview:
- Parametrised bank of NCH digital IO channel controllers; sits between the GPIO/peripheral logic and the per-pin tri-state IO buffers.
- Output side: per-channel drive-mode selection (push-pull or open-drain) and output/input enables.
- Input side: per-channel synchroniser, programmable glitch filter, edge detection and sticky interrupt status.
- Pad-facing signals are plain buffer controls (pad_o, pad_t, pad_i), so no inout appears inside the bank.

Parameters:
- NCH, 8, number of channels.
- SYNC_STAGES, 2, input synchroniser depth; legal values are 2 or more.
- FILT_W, 4, width of the filter length field and of each per-channel filter counter.

Ports:
- clk  input  1  bank clock.
- rst  input  1  synchronous active-high reset.
- cfg_oen  input  NCH  output enable, active low; 1 = channel does not drive.
- cfg_ien  input  NCH  input enable, active low; 1 = input path disabled.
- cfg_od_mode  input  NCH  1 = open-drain, 0 = push-pull.
- cfg_filt_en  input  NCH  1 = glitch filter active on that channel.
- cfg_filt_len  input  FILT_W  filter length L, shared by all channels.
- gpio_do  input  NCH  output data from core logic.
- gpio_di  output  NCH  synchronised, filtered input data.
- gpio_rise  output  NCH  one-cycle pulse on a rising edge of gpio_di.
- gpio_fall  output  NCH  one-cycle pulse on a falling edge of gpio_di.
- irq_en_rise  input  NCH  rising-edge interrupt enable.
- irq_en_fall  input  NCH  falling-edge interrupt enable.
- irq_clr  input  NCH  write-1 clear of irq_stat.
- irq_stat  output  NCH  sticky interrupt status.
- irq  output  1  OR of all irq_stat bits.
- pad_i  input  NCH  buffer output (pin value); asynchronous to clk.
- pad_o  output  NCH  buffer data input.
- pad_t  output  NCH  buffer tri-state control; 1 = hi-Z, 0 = drive.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pad_t = all 1; pad_o, gpio_di, gpio_rise, gpio_fall, irq_stat and irq = 0.
  - Synchroniser flops and filter counters = 0; per-channel prime flag = 1.
- Output path: registered, so pad_o and pad_t follow their inputs by 1 cycle.
  - Push-pull: pad_o = gpio_do, pad_t = cfg_oen.
  - Open-drain: pad_o = 0, pad_t = cfg_oen | gpio_do. The channel drives low only when enabled and gpio_do=0.
  - pad_t is never 0 while the channel is in reset.
- Synchroniser: SYNC_STAGES flops on pad_i; the final stage is s[i]. It runs while cfg_ien[i]=0.
- Input disable (cfg_ien[i]=1):
  - Synchroniser, counter and gpio_di[i] clear to 0 on the next edge.
  - gpio_rise[i] and gpio_fall[i] are forced 0, so no pulse is produced by the forced clear.
  - Prime flag is set to 1.
- Effective filter length:
  - Le = 1 when cfg_filt_en[i]=0 or cfg_filt_len=0.
  - Otherwise Le = cfg_filt_len.
- Filter, per channel:
  - If s[i] == gpio_di[i]: counter <= 0.
  - Else if counter == Le-1: gpio_di[i] <= s[i], counter <= 0.
  - Else: counter <= counter + 1.
- Filter consequences:
  - A mismatch must persist for Le consecutive cycles at s[i] to be accepted; shorter pulses are rejected with no effect on gpio_di.
  - Latency from the pad_i sampling edge to gpio_di = SYNC_STAGES + Le edges.
- Mid-run filter changes: a change to cfg_filt_len takes effect immediately. If the counter is already at or above Le-1, the next mismatching cycle accepts the value.
- Edges:
  - gpio_rise[i] is registered alongside gpio_di, set for exactly one cycle in the cycle gpio_di rises 0->1; gpio_fall[i] likewise for 1->0.
  - When prime[i]=1, the first accepted update (or the first cycle after enable with s==di) clears prime without producing a pulse.
- Interrupt status:
  - Set event = (gpio_rise & irq_en_rise) | (gpio_fall & irq_en_fall), registered into irq_stat in the cycle after the pulse.
  - irq_clr clears the bit; a set event in the same cycle wins, so the bit stays 1.
  - irq is registered: irq = |irq_stat, one cycle after irq_stat.
- Channels are fully independent; only cfg_filt_len is shared.

Test Plan:
- Reset drive check: assert rst for 3 cycles, any inputs -> pad_t=8'hFF, pad_o=0, gpio_di=0, irq=0. After release with cfg_oen=0, cfg_od_mode=0, gpio_do=8'hA5 -> pad_o=8'hA5, pad_t=0 one cycle later.
- Open-drain: ch0 with cfg_od_mode=1, cfg_oen=0, gpio_do toggling 0/1 -> pad_o[0]=0 throughout, pad_t[0]=gpio_do delayed 1 cycle.
- Unfiltered latency: ch1 with filt_en=0, pad_i[1] stepped 0->1 -> gpio_di[1]=1 exactly 3 edges later (SYNC_STAGES=2), gpio_rise[1] high for 1 cycle. With irq_en_rise[1]=1 -> irq_stat[1]=1 one cycle after the pulse, irq one cycle after that.
- Glitch reject: ch2 with filt_en=1, L=5, 4-cycle high pulse on pad_i -> gpio_di unchanged, no pulses. A 5-cycle pulse -> gpio_di high 7 edges after the step, then low 7 edges after return.
- Clear vs set: irq_clr[1]=1 in the same cycle as a new set event -> irq_stat[1] stays 1. irq_clr alone -> 0 next cycle, irq drops one cycle later.
- Disable/prime: with pad_i[3]=1 and gpio_di[3]=1, set cfg_ien[3]=1 -> gpio_di[3]=0, no fall pulse. Clear cfg_ien[3] -> gpio_di[3] returns to 1 with no rise pulse and irq_stat[3] remains 0.
